time_keeper: RTL and testbench

Time-of-day counter that consumes the slow tick produced by the clock divider and maintains a 24-hour BCD time (hh:mm:ss) for the alarm-clock display path. It detects rising edges of the tick input in the `MCLK` domain and prescales them to one-second advances. It accepts a validated time load and, optionally, compares against an alarm time and drives a ringing state machine.

---
 rtl/clock_pkg.sv | 42 ++++
 rtl/bcd_counter.sv | 39 +++
 rtl/time_keeper.sv | 216 +++++++++++++++++++++
 tb/tb_time_keeper.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : clock_pkg
//  Purpose  : Shared constants, alarm state encoding and BCD helper functions
//             for the alarm-clock time-keeping path.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package clock_pkg;

  localparam int BCD_W = 8;

  localparam logic [BCD_W-1:0] SEC_MAX  = 8'h59;
  localparam logic [BCD_W-1:0] MIN_MAX  = 8'h59;
  localparam logic [BCD_W-1:0] HOUR_MAX = 8'h23;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    RINGING = 1'b1
  } alarm_state_t;

  // True when both digits are decimal and the value does not exceed max.
  // Packed BCD with legal digits orders the same as its binary image, so a
  // plain magnitude compare against max is sufficient.
  function automatic logic bcd_valid(input logic [BCD_W-1:0] v,
                                     input logic [BCD_W-1:0] max);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max);
  endfunction

  // Two-digit BCD increment that wraps to zero after max.
  function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] v,
                                               input logic [BCD_W-1:0] max);
    if (v == max)
      return '0;
    else if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    else
      return {v[7:4], v[3:0] + 4'd1};
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_counter.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_counter
//  Purpose  : Two-digit packed-BCD modulo counter (0 .. MAX, then wrap).
//  Ports    : clk, rst      clock / asynchronous active-high reset
//             inc           advance by one this cycle
//             load          load load_val (has priority over inc)
//             load_val      packed BCD value to load
//             value         current count
//             carry         inc while at MAX (combinational, feeds next stage)
//  Revision : 1.0  initial release
// ============================================================================
module bcd_counter
  import clock_pkg::*;
#(
  parameter logic [BCD_W-1:0] MAX = SEC_MAX
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             load,
  input  logic [BCD_W-1:0] load_val,
  output logic [BCD_W-1:0] value,
  output logic             carry
);

  assign carry = inc & (value == MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      value <= '0;
    else if (load)
      value <= load_val;
    else if (inc)
      value <= bcd_inc(value, MAX);
  end

endmodule
`default_nettype wire

// File: rtl/time_keeper.sv
`default_nettype none
// ============================================================================
//  Module   : time_keeper
//  Purpose  : 24-hour BCD time-of-day counter driven by a slow tick, with a
//             validated time load and an optional alarm / ringing FSM.
//  Config   : TIME_ALARM_EN  - when defined, adds alarm ports, alarm register,
//                              ringing FSM and ring-seconds counter.
//  Ports    : MCLK, RESET_IN            clock / async active-high reset
//             TICK_IN                   slow tick (rising edges prescaled)
//             RUN                       1 = count, 0 = hold
//             LOAD, SET_HOUR/MIN/SEC    one-cycle time load request + value
//             HOUR_OUT/MIN_OUT/SEC_OUT  current time, packed BCD
//             SEC_PULSE, DAY_WRAP       one-cycle advance / midnight pulses
//             LOAD_ERR                  one-cycle pulse on a rejected request
//             ALARM_SET, ALARM_HOUR/MIN, ALARM_ACK, ALARM_HIT (TIME_ALARM_EN)
//  Revision : 1.0  initial release
// ============================================================================
module time_keeper
  import clock_pkg::*;
#(
  parameter int TICKS_PER_SEC = 1,
  parameter int RING_SECONDS  = 60
) (
  input  logic             MCLK,
  input  logic             RESET_IN,
  input  logic             TICK_IN,
  input  logic             RUN,
  input  logic             LOAD,
  input  logic [BCD_W-1:0] SET_HOUR,
  input  logic [BCD_W-1:0] SET_MIN,
  input  logic [BCD_W-1:0] SET_SEC,
`ifdef TIME_ALARM_EN
  input  logic             ALARM_SET,
  input  logic [BCD_W-1:0] ALARM_HOUR,
  input  logic [BCD_W-1:0] ALARM_MIN,
  input  logic             ALARM_ACK,
  output logic             ALARM_HIT,
`endif
  output logic [BCD_W-1:0] HOUR_OUT,
  output logic [BCD_W-1:0] MIN_OUT,
  output logic [BCD_W-1:0] SEC_OUT,
  output logic             SEC_PULSE,
  output logic             DAY_WRAP,
  output logic             LOAD_ERR
);

  localparam int            PW         = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

  logic          tick_q;
  logic          tick_qq;
  logic          tick_edge;
  logic [PW-1:0] presc;
  logic          adv_pend;
  logic          adv;
  logic          load_ok;
  logic          load_err_nxt;
  logic          sec_carry;
  logic          min_carry;
  logic          hour_carry;

  // Both sync stages reset high so a tick already high at release is not
  // mistaken for a rising edge.
  assign tick_edge = tick_q & ~tick_qq;

  assign load_ok = LOAD & bcd_valid(SET_HOUR, HOUR_MAX)
                        & bcd_valid(SET_MIN,  MIN_MAX)
                        & bcd_valid(SET_SEC,  SEC_MAX);

  // The advance is pipelined one stage behind the prescaler wrap; any LOAD
  // arriving in either stage takes priority and discards the advance.
  assign adv = adv_pend & ~LOAD;

  always_ff @(posedge MCLK or posedge RESET_IN) begin
    if (RESET_IN) begin
      tick_q    <= 1'b1;
      tick_qq   <= 1'b1;
      presc     <= '0;
      adv_pend  <= 1'b0;
      SEC_PULSE <= 1'b0;
      DAY_WRAP  <= 1'b0;
      LOAD_ERR  <= 1'b0;
    end else begin
      tick_q    <= TICK_IN;
      tick_qq   <= tick_q;
      adv_pend  <= 1'b0;
      if (load_ok) begin
        presc <= '0;
      end else if (RUN && tick_edge) begin
        if (presc == PRESC_LAST) begin
          presc    <= '0;
          adv_pend <= ~LOAD;
        end else begin
          presc <= presc + PW'(1);
        end
      end
      SEC_PULSE <= adv;
      DAY_WRAP  <= hour_carry;
      LOAD_ERR  <= load_err_nxt;
    end
  end

  bcd_counter #(.MAX(SEC_MAX)) u_sec (
    .clk      (MCLK),
    .rst      (RESET_IN),
    .inc      (adv),
    .load     (load_ok),
    .load_val (SET_SEC),
    .value    (SEC_OUT),
    .carry    (sec_carry)
  );

  bcd_counter #(.MAX(MIN_MAX)) u_min (
    .clk      (MCLK),
    .rst      (RESET_IN),
    .inc      (sec_carry),
    .load     (load_ok),
    .load_val (SET_MIN),
    .value    (MIN_OUT),
    .carry    (min_carry)
  );

  bcd_counter #(.MAX(HOUR_MAX)) u_hour (
    .clk      (MCLK),
    .rst      (RESET_IN),
    .inc      (min_carry),
    .load     (load_ok),
    .load_val (SET_HOUR),
    .value    (HOUR_OUT),
    .carry    (hour_carry)
  );

`ifdef TIME_ALARM_EN
  localparam logic [7:0] RING_LAST = 8'(RING_SECONDS - 1);

  alarm_state_t     state;
  alarm_state_t     state_nxt;
  logic [7:0]       ring_cnt;
  logic [7:0]       ring_cnt_nxt;
  logic [BCD_W-1:0] al_hour;
  logic [BCD_W-1:0] al_min;
  logic             al_valid;
  logic             alarm_ok;
  logic             alarm_match;

  assign alarm_ok = bcd_valid(ALARM_HOUR, HOUR_MAX) & bcd_valid(ALARM_MIN, MIN_MAX);

  // The post-advance time can only be hh:mm:00 when the seconds wrap, so the
  // match looks at the incremented minute/hour values during that advance.
  // A LOAD never produces sec_carry, so loading the alarm time cannot trigger.
  assign alarm_match = al_valid & sec_carry
                     & (bcd_inc(MIN_OUT, MIN_MAX) == al_min)
                     & ((min_carry ? bcd_inc(HOUR_OUT, HOUR_MAX) : HOUR_OUT) == al_hour);

  assign load_err_nxt = (LOAD & ~load_ok) | (ALARM_SET & ~alarm_ok);

  always_comb begin
    state_nxt    = state;
    ring_cnt_nxt = ring_cnt;
    if (ALARM_SET && alarm_ok) begin
      state_nxt    = IDLE;
      ring_cnt_nxt = '0;
    end else begin
      case (state)
        IDLE: begin
          if (alarm_match)
            state_nxt = RINGING;
        end
        RINGING: begin
          if (ALARM_ACK) begin
            state_nxt    = IDLE;
            ring_cnt_nxt = '0;
          end else if (adv) begin
            // The advance that starts ringing is seen in IDLE, so only the
            // following RING_SECONDS advances are counted here.
            if (ring_cnt == RING_LAST) begin
              state_nxt    = IDLE;
              ring_cnt_nxt = '0;
            end else begin
              ring_cnt_nxt = ring_cnt + 8'd1;
            end
          end
        end
        default: begin
          state_nxt    = IDLE;
          ring_cnt_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge MCLK or posedge RESET_IN) begin
    if (RESET_IN) begin
      state     <= IDLE;
      ring_cnt  <= '0;
      al_hour   <= '0;
      al_min    <= '0;
      al_valid  <= 1'b0;
      ALARM_HIT <= 1'b0;
    end else begin
      state     <= state_nxt;
      ring_cnt  <= ring_cnt_nxt;
      ALARM_HIT <= (state_nxt == RINGING);
      if (ALARM_SET && alarm_ok) begin
        al_hour  <= ALARM_HOUR;
        al_min   <= ALARM_MIN;
        al_valid <= 1'b1;
      end
    end
  end
`else
  assign load_err_nxt = LOAD & ~load_ok;
`endif

endmodule
`default_nettype wire

// File: tb/tb_time_keeper.sv
`default_nettype none
// ============================================================================
//  Module   : tb_time_keeper
//  Purpose  : Directed self-checking bench for time_keeper (TICKS_PER_SEC=100,
//             RING_SECONDS=3). Alarm checks are built when TIME_ALARM_EN is
//             defined.
//  Ports    : none
//  Revision : 1.0  initial release
// ============================================================================
module tb_time_keeper;

  localparam int TPS = 100;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick_in;
  logic       run;
  logic       load;
  logic [7:0] set_hour, set_min, set_sec;
  logic [7:0] hour_out, min_out, sec_out;
  logic       sec_pulse, day_wrap, load_err;
`ifdef TIME_ALARM_EN
  logic       alarm_set;
  logic [7:0] alarm_hour, alarm_min;
  logic       alarm_ack;
  logic       alarm_hit;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  int pulse_cnt    = 0;
  int wrap_cnt     = 0;
  int wrap_alone   = 0;

  // probe samples: one cycle before and at the expected advance cycle
  logic [7:0] sec_p2, sec_p3;
  logic       pulse_p2, pulse_p3;
  logic       hit_p2, hit_p3;

  typedef struct {
    logic [7:0] h, m, s;
    logic [7:0] eh, em, es;
    logic       err;
  } load_vec_t;

  load_vec_t tbl [8];

  always #5 clk = ~clk;

  time_keeper #(.TICKS_PER_SEC(TPS), .RING_SECONDS(3)) dut (
    .MCLK       (clk),
    .RESET_IN   (rst),
    .TICK_IN    (tick_in),
    .RUN        (run),
    .LOAD       (load),
    .SET_HOUR   (set_hour),
    .SET_MIN    (set_min),
    .SET_SEC    (set_sec),
`ifdef TIME_ALARM_EN
    .ALARM_SET  (alarm_set),
    .ALARM_HOUR (alarm_hour),
    .ALARM_MIN  (alarm_min),
    .ALARM_ACK  (alarm_ack),
    .ALARM_HIT  (alarm_hit),
`endif
    .HOUR_OUT   (hour_out),
    .MIN_OUT    (min_out),
    .SEC_OUT    (sec_out),
    .SEC_PULSE  (sec_pulse),
    .DAY_WRAP   (day_wrap),
    .LOAD_ERR   (load_err)
  );

  always @(negedge clk) begin
    if (sec_pulse) pulse_cnt <= pulse_cnt + 1;
    if (day_wrap)  wrap_cnt  <= wrap_cnt + 1;
    if (day_wrap && !sec_pulse) wrap_alone <= wrap_alone + 1;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic edges(input int n);
    repeat (n) begin
      tick_in = 1'b1; cyc(2);
      tick_in = 1'b0; cyc(2);
    end
  endtask

  // One final edge; the rising level is first sampled at edge n, so the
  // advance should appear right after edge n+2.
  task automatic probe_edge();
    tick_in  = 1'b1; cyc(2);
    sec_p2   = sec_out;
    pulse_p2 = sec_pulse;
`ifdef TIME_ALARM_EN
    hit_p2   = alarm_hit;
`else
    hit_p2   = 1'b0;
`endif
    cyc(1);
    sec_p3   = sec_out;
    pulse_p3 = sec_pulse;
`ifdef TIME_ALARM_EN
    hit_p3   = alarm_hit;
`else
    hit_p3   = 1'b0;
`endif
    tick_in  = 1'b0; cyc(2);
  endtask

  task automatic advance_one();
    edges(TPS - 1);
    probe_edge();
  endtask

  task automatic do_load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    set_hour = h; set_min = m; set_sec = s;
    load = 1'b1; cyc(1);
    load = 1'b0;
  endtask

  int p0, w0;

  initial begin
    tbl[0] = '{8'h12, 8'h34, 8'h56, 8'h12, 8'h34, 8'h56, 1'b0};
    tbl[1] = '{8'h24, 8'h00, 8'h00, 8'h12, 8'h34, 8'h56, 1'b1};
    tbl[2] = '{8'h12, 8'h5A, 8'h00, 8'h12, 8'h34, 8'h56, 1'b1};
    tbl[3] = '{8'h00, 8'h60, 8'h00, 8'h12, 8'h34, 8'h56, 1'b1};
    tbl[4] = '{8'h1A, 8'h00, 8'h00, 8'h12, 8'h34, 8'h56, 1'b1};
    tbl[5] = '{8'h09, 8'h09, 8'h09, 8'h09, 8'h09, 8'h09, 1'b0};
    tbl[6] = '{8'h23, 8'h59, 8'h5F, 8'h09, 8'h09, 8'h09, 1'b1};
    tbl[7] = '{8'h23, 8'h59, 8'h59, 8'h23, 8'h59, 8'h59, 1'b0};

    rst = 1'b1; tick_in = 1'b1; run = 1'b1; load = 1'b0;
    set_hour = '0; set_min = '0; set_sec = '0;
`ifdef TIME_ALARM_EN
    alarm_set = 1'b0; alarm_hour = '0; alarm_min = '0; alarm_ack = 1'b0;
`endif
    cyc(3);
    rst = 1'b0;
    cyc(1);

    // reset values, high tick at release must not count
    check("reset_hour", hour_out, 8'h00);
    check("reset_min",  min_out,  8'h00);
    check("reset_sec",  sec_out,  8'h00);
    check("reset_flags", {sec_pulse, day_wrap, load_err}, 3'b000);
`ifdef TIME_ALARM_EN
    check("reset_hit", alarm_hit, 1'b0);
`endif
    cyc(10);
    check("no_pulse_after_reset", pulse_cnt, 0);

    // 100 edges -> exactly one advance, with n+2 latency
    tick_in = 1'b0; cyc(2);
    edges(TPS - 1);
    check("no_pulse_99_edges", pulse_cnt, 0);
    probe_edge();
    check("adv_sec_before", sec_p2, 8'h00);
    check("adv_pulse_before", pulse_p2, 1'b0);
    check("adv_sec_at_n2", sec_p3, 8'h01);
    check("adv_pulse_at_n2", pulse_p3, 1'b1);
    cyc(2);
    check("one_pulse_100_edges", pulse_cnt, 1);

    // load validation table
    run = 1'b0;
    for (int i = 0; i < 8; i++) begin
      do_load(tbl[i].h, tbl[i].m, tbl[i].s);
      check($sformatf("load%0d_hour", i), hour_out, tbl[i].eh);
      check($sformatf("load%0d_min",  i), min_out,  tbl[i].em);
      check($sformatf("load%0d_sec",  i), sec_out,  tbl[i].es);
      check($sformatf("load%0d_err",  i), load_err, tbl[i].err);
      cyc(1);
      check($sformatf("load%0d_err_clear", i), load_err, 1'b0);
    end

    // midnight wrap from 23:59:59
    run = 1'b1;
    p0 = pulse_cnt; w0 = wrap_cnt;
    edges(TPS);
    cyc(2);
    check("wrap_hour", hour_out, 8'h00);
    check("wrap_min",  min_out,  8'h00);
    check("wrap_sec",  sec_out,  8'h00);
    check("wrap_pulses", pulse_cnt - p0, 1);
    check("wrap_day_wrap", wrap_cnt - w0, 1);
    check("wrap_with_pulse", wrap_alone, 0);

    // RUN=0 holds time
    run = 1'b0;
    p0 = pulse_cnt;
    edges(TPS + 5);
    check("hold_sec", sec_out, 8'h00);
    check("hold_pulses", pulse_cnt - p0, 0);

    // LOAD in the advance cycle wins
    do_load(8'h10, 8'h00, 8'h00);
    run = 1'b1;
    edges(TPS - 1);
    p0 = pulse_cnt;
    tick_in = 1'b1; cyc(2);
    set_hour = 8'h05; set_min = 8'h06; set_sec = 8'h07;
    load = 1'b1; tick_in = 1'b0; cyc(1);
    load = 1'b0;
    check("collide_hour", hour_out, 8'h05);
    check("collide_min",  min_out,  8'h06);
    check("collide_sec",  sec_out,  8'h07);
    check("collide_no_pulse", sec_pulse, 1'b0);
    cyc(3);
    check("collide_no_pulse_later", pulse_cnt - p0, 0);
    check("collide_sec_later", sec_out, 8'h07);

`ifdef TIME_ALARM_EN
    // invalid alarm is rejected
    alarm_hour = 8'h25; alarm_min = 8'h00; alarm_set = 1'b1; cyc(1);
    alarm_set = 1'b0;
    check("alarm_bad_err", load_err, 1'b1);

    alarm_hour = 8'h07; alarm_min = 8'h30; alarm_set = 1'b1; cyc(1);
    alarm_set = 1'b0;
    check("alarm_ok_err", load_err, 1'b0);

    // loading the alarm time itself does not ring
    do_load(8'h07, 8'h30, 8'h00);
    cyc(2);
    check("alarm_load_no_hit", alarm_hit, 1'b0);

    // ring then auto-stop after 3 more seconds
    do_load(8'h07, 8'h29, 8'h59);
    advance_one();
    check("ring_hit_before", hit_p2, 1'b0);
    check("ring_hit_rise", hit_p3, 1'b1);
    check("ring_time", {hour_out, min_out, sec_out}, 24'h073000);
    advance_one();
    check("ring_hit_s1", hit_p3, 1'b1);
    advance_one();
    check("ring_hit_s2", hit_p3, 1'b1);
    advance_one();
    check("ring_hit_s3_off", hit_p3, 1'b0);

    // ring then acknowledge
    do_load(8'h07, 8'h29, 8'h59);
    advance_one();
    check("ack_hit_rise", hit_p3, 1'b1);
    cyc(3);
    check("ack_hit_held", alarm_hit, 1'b1);
    alarm_ack = 1'b1; cyc(1);
    alarm_ack = 1'b0;
    check("ack_hit_fall", alarm_hit, 1'b0);
    cyc(2);
    check("ack_hit_stays_low", alarm_hit, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
